// File: rtl/ball_track_pkg.sv
// Shared encodings and frame geometry for the red-ball motion tracker.
package ball_track_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    LOST    = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_LEFT  = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_UP    = 3'd3,
    DIR_DOWN  = 3'd4
  } dir_e;

  localparam int          FRAME_W = 640;
  localparam int          FRAME_H = 480;
  localparam int          H_MAX   = FRAME_W - 1;
  localparam int          V_MAX   = FRAME_H - 1;
  localparam logic [18:0] PIX_MAX = 19'd307199;

endpackage

// File: rtl/axis_smoother.sv
// One-axis exponential smoother: load raw, or step by (raw-filt)>>>SHIFT, clamped to 0..MAXV.
module axis_smoother #(
  parameter int W     = 10,
  parameter int MAXV  = 639,
  parameter int SHIFT = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         upd_i,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] filt_o,
  output logic [W-1:0] nxt_o
);

  localparam logic signed [11:0] MAXS = 12'(MAXV);

  logic [W-1:0]       filt_q, filt_d, ld_val;
  logic signed [11:0] diff, sum;

  always_comb begin
    diff = $signed(12'(raw_i)) - $signed(12'(filt_q));
    sum  = $signed(12'(filt_q)) + (diff >>> SHIFT);
    if (sum < 0)         nxt_o = '0;
    else if (sum > MAXS) nxt_o = W'(MAXV);
    else                 nxt_o = sum[W-1:0];
    ld_val = ($signed(12'(raw_i)) > MAXS) ? W'(MAXV) : raw_i;
    filt_d = filt_q;
    if (load_i)     filt_d = ld_val;
    else if (upd_i) filt_d = nxt_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) filt_q <= '0;
    else         filt_q <= filt_d;
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/ball_motion_tracker.sv
// Per-frame target presence FSM, position smoothing and move-event generation
// for the red-ball detector, all in the VGA pixel clock domain.
module ball_motion_tracker
  import ball_track_pkg::*;
#(
  parameter int MIN_PIXELS     = 256,
  parameter int ACQUIRE_FRAMES = 3,
  parameter int LOST_FRAMES    = 5,
  parameter int MOVE_THRESH    = 40,
  parameter int SMOOTH_SHIFT   = 2,
  parameter int HOLDOFF_FRAMES = 8
) (
  input  logic       iVgaClk,
  input  logic       reset,
  input  logic       iVgaRequest,
  input  logic       iVgaVRequest,
  input  logic       iIsPixelRed,
  input  logic [9:0] iRedColumn,
  input  logic [8:0] iRedRow,
  output logic [9:0] oTargetH,
  output logic [8:0] oTargetV,
  output logic       oTargetValid,
  output logic       oMoveEvent,
  output logic [2:0] oMoveDir,
  output logic [1:0] oState
);

  localparam int                 CW   = 16;
  localparam logic signed [11:0] THR  = 12'(MOVE_THRESH);
  localparam logic [CW-1:0]      ACQN = CW'(ACQUIRE_FRAMES);
  localparam logic [CW-1:0]      LOSN = CW'(LOST_FRAMES);
  localparam logic [CW-1:0]      HOLD = CW'(HOLDOFF_FRAMES);

  state_e             state_q, state_d;
  dir_e               dir_q, dir_d;
  logic               vreq_q, fe_q, ev_q, ev_d;
  logic [18:0]        cnt_q, cnt_d;
  logic [CW-1:0]      run_q, run_d, miss_q, miss_d, hold_q, hold_d;
  logic [9:0]         ref_h_q, ref_h_d, filt_h, nxt_h;
  logic [8:0]         ref_v_q, ref_v_d, filt_v, nxt_v;
  logic               present, ld, upd;
  logic signed [11:0] dh, dv, adh, adv;

  axis_smoother #(.W(10), .MAXV(H_MAX), .SHIFT(SMOOTH_SHIFT)) u_sm_h (
    .clk_i(iVgaClk), .rst_ni(reset), .load_i(ld), .upd_i(upd),
    .raw_i(iRedColumn), .filt_o(filt_h), .nxt_o(nxt_h)
  );

  axis_smoother #(.W(9), .MAXV(V_MAX), .SHIFT(SMOOTH_SHIFT)) u_sm_v (
    .clk_i(iVgaClk), .rst_ni(reset), .load_i(ld), .upd_i(upd),
    .raw_i(iRedRow), .filt_o(filt_v), .nxt_o(nxt_v)
  );

  always_comb begin
    present = (cnt_q >= 19'(MIN_PIXELS));
    cnt_d   = cnt_q;
    // Frame end wins over a coincident red pixel so every frame starts at zero.
    if (fe_q)                                                 cnt_d = '0;
    else if (iVgaRequest && iIsPixelRed && cnt_q != PIX_MAX)  cnt_d = cnt_q + 19'd1;

    dh  = $signed(12'(nxt_h)) - $signed(12'(ref_h_q));
    dv  = $signed(12'(nxt_v)) - $signed(12'(ref_v_q));
    adh = dh[11] ? -dh : dh;
    adv = dv[11] ? -dv : dv;

    state_d = state_q;
    run_d   = run_q;
    miss_d  = miss_q;
    hold_d  = hold_q;
    ref_h_d = ref_h_q;
    ref_v_d = ref_v_q;
    dir_d   = dir_q;
    ev_d    = 1'b0;
    ld      = 1'b0;
    upd     = 1'b0;

    if (fe_q) begin
      unique case (state_q)
        SEARCH: if (present) begin
          state_d = ACQUIRE;
          run_d   = CW'(1);
        end
        ACQUIRE: begin
          if (!present) state_d = SEARCH;
          else if (run_q + CW'(1) == ACQN) begin
            state_d = TRACK;
            ld      = 1'b1;
            ref_h_d = iRedColumn;
            ref_v_d = iRedRow;
            hold_d  = '0;
          end else run_d = run_q + CW'(1);
        end
        TRACK: begin
          if (present && hold_q == '0 && (adh >= THR || adv >= THR)) begin
            upd     = 1'b1;
            ev_d    = 1'b1;
            ref_h_d = nxt_h;
            ref_v_d = nxt_v;
            hold_d  = HOLD;
            // Horizontal wins ties.
            if (adh >= adv) dir_d = dh[11] ? DIR_LEFT : DIR_RIGHT;
            else            dir_d = dv[11] ? DIR_UP   : DIR_DOWN;
          end else begin
            upd = present;
            if (hold_q != '0) hold_d = hold_q - CW'(1);
            if (!present) begin
              state_d = LOST;
              miss_d  = CW'(1);
            end
          end
        end
        LOST: begin
          if (present) begin
            state_d = TRACK;
            upd     = 1'b1;
            miss_d  = '0;
          end else if (miss_q + CW'(1) == LOSN) state_d = SEARCH;
          else miss_d = miss_q + CW'(1);
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge iVgaClk) begin
    if (!reset) begin
      state_q <= SEARCH;
      vreq_q  <= 1'b0;
      fe_q    <= 1'b0;
      cnt_q   <= '0;
      run_q   <= '0;
      miss_q  <= '0;
      hold_q  <= '0;
      ref_h_q <= '0;
      ref_v_q <= '0;
      ev_q    <= 1'b0;
      dir_q   <= DIR_NONE;
    end else begin
      state_q <= state_d;
      vreq_q  <= iVgaVRequest;
      fe_q    <= vreq_q & ~iVgaVRequest;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      miss_q  <= miss_d;
      hold_q  <= hold_d;
      ref_h_q <= ref_h_d;
      ref_v_q <= ref_v_d;
      ev_q    <= ev_d;
      dir_q   <= dir_d;
    end
  end

  assign oTargetH     = filt_h;
  assign oTargetV     = filt_v;
  assign oTargetValid = (state_q == TRACK);
  assign oMoveEvent   = ev_q;
  assign oMoveDir     = dir_q;
  assign oState       = state_q;

endmodule

// File: tb/tb_ball_motion_tracker.sv
// Bench for ball_motion_tracker: constant vector table, corner-case sequences,
// and random frames against a frame-level reference model.
module tb_ball_motion_tracker;

  localparam int MINP = 256, ACQ = 3, LOSTN = 5, THR = 40, SH = 2, HOLDN = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       iVgaRequest = 1'b0, iVgaVRequest = 1'b0, iIsPixelRed = 1'b0;
  logic [9:0] iRedColumn = '0;
  logic [8:0] iRedRow = '0;
  logic [9:0] oTargetH;
  logic [8:0] oTargetV;
  logic       oTargetValid, oMoveEvent;
  logic [2:0] oMoveDir;
  logic [1:0] oState;

  ball_motion_tracker #(
    .MIN_PIXELS(MINP), .ACQUIRE_FRAMES(ACQ), .LOST_FRAMES(LOSTN),
    .MOVE_THRESH(THR), .SMOOTH_SHIFT(SH), .HOLDOFF_FRAMES(HOLDN)
  ) dut (
    .iVgaClk(clk), .reset(reset), .iVgaRequest(iVgaRequest), .iVgaVRequest(iVgaVRequest),
    .iIsPixelRed(iIsPixelRed), .iRedColumn(iRedColumn), .iRedRow(iRedRow),
    .oTargetH(oTargetH), .oTargetV(oTargetV), .oTargetValid(oTargetValid),
    .oMoveEvent(oMoveEvent), .oMoveDir(oMoveDir), .oState(oState)
  );

  always #5 clk = ~clk;

  typedef struct {
    int npix; int col; int row;
    int st; int h; int v; int ev; int dir;
  } vec_t;

  vec_t tbl[$];
  int total = 0, bad = 0;
  int ev_cnt, st_early;

  // reference model state
  int m_st, m_run, m_miss, m_hold, m_fh, m_fv, m_rh, m_rv, m_dir, m_ev;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (oMoveEvent) ev_cnt++;
  endtask

  task automatic do_reset();
    reset = 1'b0; iVgaVRequest = 1'b0; iVgaRequest = 1'b0; iIsPixelRed = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  // One frame: npix counted red pixels, some non-counting cycles, then VRequest fall.
  task automatic frame(input int npix, input int col, input int row);
    ev_cnt = 0;
    iVgaVRequest = 1'b1;
    iRedColumn = 10'(col); iRedRow = 9'(row);
    tick();
    for (int i = 0; i < npix; i++) begin iVgaRequest = 1'b1; iIsPixelRed = 1'b1; tick(); end
    iIsPixelRed = 1'b0;
    repeat (4) tick();
    iVgaRequest = 1'b0; iIsPixelRed = 1'b1;
    repeat (4) tick();
    iIsPixelRed = 1'b0;
    iVgaVRequest = 1'b0;
    tick();
    st_early = int'(oState);
    tick(); tick();
  endtask

  task automatic add(input int np, input int c, input int r, input int st,
                     input int h, input int v, input int ev, input int dir);
    vec_t e;
    e.npix = np; e.col = c; e.row = r; e.st = st; e.h = h; e.v = v; e.ev = ev; e.dir = dir;
    tbl.push_back(e);
  endtask

  function automatic int smooth(input int f, input int r, input int mx);
    int d, k, s;
    k = 1 << SH;
    d = r - f;
    s = (d >= 0) ? d / k : -((-d + k - 1) / k);
    s = f + s;
    if (s < 0) s = 0;
    if (s > mx) s = mx;
    return s;
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset();
    m_st = 0; m_run = 0; m_miss = 0; m_hold = 0;
    m_fh = 0; m_fv = 0; m_rh = 0; m_rv = 0; m_dir = 0; m_ev = 0;
  endtask

  task automatic model_frame(input int npix, input int col, input int row);
    bit pres;
    int dh, dv;
    pres = (npix >= MINP);
    m_ev = 0;
    case (m_st)
      0: if (pres) begin m_st = 1; m_run = 1; end
      1: begin
        if (!pres) m_st = 0;
        else if (m_run + 1 == ACQ) begin
          m_st = 2; m_fh = col; m_fv = row; m_rh = col; m_rv = row; m_hold = 0;
        end else m_run++;
      end
      2: begin
        if (pres) begin
          m_fh = smooth(m_fh, col, 639);
          m_fv = smooth(m_fv, row, 479);
          dh = m_fh - m_rh; dv = m_fv - m_rv;
          if (m_hold == 0 && (iabs(dh) >= THR || iabs(dv) >= THR)) begin
            m_ev = 1;
            if (iabs(dh) >= iabs(dv)) m_dir = (dh < 0) ? 1 : 2;
            else                      m_dir = (dv < 0) ? 3 : 4;
            m_rh = m_fh; m_rv = m_fv; m_hold = HOLDN;
          end else if (m_hold > 0) m_hold--;
        end else begin
          m_st = 3; m_miss = 1;
          if (m_hold > 0) m_hold--;
        end
      end
      default: begin
        if (pres) begin
          m_st = 2; m_miss = 0;
          m_fh = smooth(m_fh, col, 639);
          m_fv = smooth(m_fv, row, 479);
        end else if (m_miss + 1 == LOSTN) m_st = 0;
        else m_miss++;
      end
    endcase
  endtask

  initial begin
    int col, row, np;

    // Reset state
    do_reset();
    check("rst state", int'(oState), 0);
    check("rst H", int'(oTargetH), 0);
    check("rst V", int'(oTargetV), 0);
    check("rst valid", int'(oTargetValid), 0);
    check("rst event", int'(oMoveEvent), 0);
    check("rst dir", int'(oMoveDir), 0);

    // Acquire, step right, holdoff, lose and re-acquire, fall back to SEARCH
    repeat (2) add(300, 320, 240, 1, 0, 0, 0, 0);
    add(300, 320, 240, 2, 320, 240, 0, 0);
    add(300, 400, 240, 2, 340, 240, 0, 0);
    add(300, 400, 240, 2, 355, 240, 0, 0);
    add(300, 400, 240, 2, 366, 240, 1, 2);
    add(300, 600, 240, 2, 424, 240, 0, 2);
    add(300, 600, 240, 2, 468, 240, 0, 2);
    add(300, 600, 240, 2, 501, 240, 0, 2);
    add(300, 600, 240, 2, 525, 240, 0, 2);
    add(300, 600, 240, 2, 543, 240, 0, 2);
    add(300, 600, 240, 2, 557, 240, 0, 2);
    add(300, 600, 240, 2, 567, 240, 0, 2);
    add(300, 600, 240, 2, 575, 240, 0, 2);
    add(300, 600, 240, 2, 581, 240, 1, 2);
    repeat (4) add(0, 600, 240, 3, 581, 240, 0, 2);
    add(300, 600, 240, 2, 585, 240, 0, 2);
    repeat (4) add(0, 600, 240, 3, 585, 240, 0, 2);
    add(0, 600, 240, 0, 585, 240, 0, 2);

    foreach (tbl[i]) begin
      frame(tbl[i].npix, tbl[i].col, tbl[i].row);
      check($sformatf("vec%0d state", i), int'(oState), tbl[i].st);
      check($sformatf("vec%0d valid", i), int'(oTargetValid), (tbl[i].st == 2) ? 1 : 0);
      check($sformatf("vec%0d H", i), int'(oTargetH), tbl[i].h);
      check($sformatf("vec%0d V", i), int'(oTargetV), tbl[i].v);
      check($sformatf("vec%0d events", i), ev_cnt, tbl[i].ev);
      check($sformatf("vec%0d dir", i), int'(oMoveDir), tbl[i].dir);
    end

    // Presence threshold and update latency
    do_reset();
    repeat (3) begin
      frame(255, 100, 100);
      check("255px state", int'(oState), 0);
    end
    frame(256, 100, 100);
    check("256px early state", st_early, 0);
    check("256px state", int'(oState), 1);

    // Equal horizontal/vertical displacement resolves horizontally
    do_reset();
    repeat (3) frame(300, 320, 240);
    frame(300, 500, 60);
    check("tie events", ev_cnt, 1);
    check("tie dir", int'(oMoveDir), 2);
    check("tie H", int'(oTargetH), 365);
    check("tie V", int'(oTargetV), 195);

    // VRequest held high: no frame end, no change
    ev_cnt = 0;
    iVgaVRequest = 1'b1;
    iVgaRequest = 1'b1; iIsPixelRed = 1'b1;
    repeat (400) tick();
    check("vhigh state", int'(oState), 2);
    check("vhigh events", ev_cnt, 0);
    check("vhigh H", int'(oTargetH), 365);

    // Reset in the middle of a frame discards the partial count
    repeat (600) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    iVgaRequest = 1'b0; iIsPixelRed = 1'b0;
    check("midrst state", int'(oState), 0);
    check("midrst H", int'(oTargetH), 0);
    check("midrst V", int'(oTargetV), 0);
    check("midrst dir", int'(oMoveDir), 0);
    check("midrst valid", int'(oTargetValid), 0);
    frame(100, 320, 240);
    check("after midrst state", int'(oState), 0);

    // Random frames against the reference model
    do_reset();
    model_reset();
    col = 320; row = 240;
    for (int f = 0; f < 120; f++) begin
      if ((f % 40) >= 30 && (f % 40) < 36) np = int'($urandom_range(0, 255));
      else if ($urandom_range(0, 5) == 0) np = int'($urandom_range(200, 255));
      else np = int'($urandom_range(256, 300));
      if ($urandom_range(0, 4) == 0) begin
        col = int'($urandom_range(0, 639));
        row = int'($urandom_range(0, 479));
      end else begin
        col += int'($urandom_range(0, 80)) - 40;
        row += int'($urandom_range(0, 80)) - 40;
        if (col < 0) col = 0;
        if (col > 639) col = 639;
        if (row < 0) row = 0;
        if (row > 479) row = 479;
      end
      frame(np, col, row);
      model_frame(np, col, row);
      check($sformatf("rnd%0d state", f), int'(oState), m_st);
      check($sformatf("rnd%0d valid", f), int'(oTargetValid), (m_st == 2) ? 1 : 0);
      check($sformatf("rnd%0d H", f), int'(oTargetH), m_fh);
      check($sformatf("rnd%0d V", f), int'(oTargetV), m_fv);
      check($sformatf("rnd%0d events", f), ev_cnt, m_ev);
      check($sformatf("rnd%0d dir", f), int'(oMoveDir), m_dir);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
